// File: rtl/prbs31_pkg.sv
// Shared types and constants for the PRBS31 bit-error-rate tester.
package prbs31_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  localparam logic [PRBS_LEN-1:0] DEFAULT_SEED = 31'd1;

endpackage

// File: rtl/prbs31_bert_ctrl_if.sv
// Control/status and serial bit bundle of the BERT controller.
interface prbs31_bert_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             inject_err;
  logic             rx_bit;
  logic             tx_bit;
  logic [1:0]       state;
  logic             locked;
  logic             done;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output start, stop, inject_err, rx_bit,
    input  tx_bit, state, locked, done, lock_lost, err_count, bit_count
  );

  modport slave (
    input  start, stop, inject_err, rx_bit,
    output tx_bit, state, locked, done, lock_lost, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_lfsr.sv
// 31-bit shift register for x^31+x^28+1. With EXT_IN=0 it free-runs on its
// own feedback and presents the MSB; with EXT_IN=1 it shifts in ext_bit and
// presents the tap XOR, i.e. the bit the sequence predicts next.
module prbs31_lfsr
  import prbs31_pkg::*;
#(
  parameter bit EXT_IN = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [PRBS_LEN-1:0] load_value,
  input  logic                ext_bit,
  output logic                out_bit
);
  logic [PRBS_LEN-1:0] q;
  logic                fb;
  logic                shift_in;

  assign fb       = q[TAP_A] ^ q[TAP_B];
  assign shift_in = EXT_IN ? ext_bit : fb;
  assign out_bit  = EXT_IN ? fb : q[TAP_A];

  // Register update: load has priority over shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (en) begin
      q <= {q[PRBS_LEN-2:0], shift_in};
    end
  end
endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 BERT controller: generator, self-synchronising checker, and the
// run/measure FSM with bit, error and consecutive-error counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no run; generator frozen, tx low, counters held for readout
// ST_SEED  | filling the checker with 31 received bits, no error counting
// ST_CHECK | locked; every received bit compared and counted
// ST_DONE  | window complete; results held until next start
module prbs31_bert_ctrl
  import prbs31_pkg::*;
#(
  parameter int                  WINDOW      = 1024,
  parameter int                  CNT_W       = 16,
  parameter int                  LOSS_THRESH = 8,
  parameter logic [PRBS_LEN-1:0] SEED        = DEFAULT_SEED
) (
  input logic              clk,
  input logic              rst_n,
  prbs31_bert_ctrl_if.slave bus
);
  localparam int               CW       = $clog2(LOSS_THRESH + 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CW-1:0]    CON_LAST = CW'(LOSS_THRESH - 1);
  localparam logic [4:0]       LOAD_END = 5'(PRBS_LEN - 1);

  state_t           st;
  logic [4:0]       load_cnt;
  logic [CW-1:0]    consec;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  logic             lock_lost;

  logic running;
  logic begin_run;
  logic gen_bit;
  logic expected;
  logic err;
  logic loss;

  assign running   = (st == ST_SEED) || (st == ST_CHECK);
  assign begin_run = ((st == ST_IDLE) || (st == ST_DONE)) && bus.start && !bus.stop;
  assign err       = bus.rx_bit ^ expected;
  assign loss      = err && (consec == CON_LAST);

  prbs31_lfsr #(.EXT_IN(1'b0)) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (running),
    .load       (begin_run),
    .load_value (SEED),
    .ext_bit    (1'b0),
    .out_bit    (gen_bit)
  );

  prbs31_lfsr #(.EXT_IN(1'b1)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (running),
    .load       (begin_run),
    .load_value ('0),
    .ext_bit    (bus.rx_bit),
    .out_bit    (expected)
  );

  assign bus.tx_bit    = running ? (gen_bit ^ bus.inject_err) : 1'b0;
  assign bus.state     = st;
  assign bus.locked    = (st == ST_CHECK);
  assign bus.done      = (st == ST_DONE);
  assign bus.lock_lost = lock_lost;
  assign bus.err_count = err_count;
  assign bus.bit_count = bit_count;

  // Run sequencing and measurement counters; stop wins over everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      load_cnt  <= '0;
      consec    <= '0;
      err_count <= '0;
      bit_count <= '0;
      lock_lost <= 1'b0;
    end else if (bus.stop) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            st        <= ST_SEED;
            load_cnt  <= '0;
            consec    <= '0;
            err_count <= '0;
            bit_count <= '0;
            lock_lost <= 1'b0;
          end
        end
        ST_SEED: begin
          load_cnt <= load_cnt + 5'd1;
          if (load_cnt == LOAD_END) st <= ST_CHECK;
        end
        ST_CHECK: begin
          bit_count <= bit_count + 1'b1;
          if (err) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            consec <= consec + 1'b1;
          end else begin
            consec <= '0;
          end
          // Window end beats resync, but the loss is still recorded.
          if (bit_count == WIN_LAST) begin
            st <= ST_DONE;
            if (loss) lock_lost <= 1'b1;
          end else if (loss) begin
            st        <= ST_SEED;
            load_cnt  <= '0;
            consec    <= '0;
            lock_lost <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// Directed bench for the PRBS31 BERT controller. Cycle index cyc counts
// rising edges after the edge that sampled start (cyc=0 right after it).
module tb_prbs31_bert_ctrl;
  import prbs31_pkg::*;

  localparam int CNT_W  = 16;
  localparam int WINDOW = 1024;
  localparam int LT     = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic loop_en;
  logic rx_force;

  always #5 clk = ~clk;

  prbs31_bert_ctrl_if #(.CNT_W(CNT_W)) bif ();

  assign bif.rx_bit = loop_en ? bif.tx_bit : rx_force;

  prbs31_bert_ctrl #(
    .WINDOW      (WINDOW),
    .CNT_W       (CNT_W),
    .LOSS_THRESH (LT),
    .SEED        (31'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  logic [30:0] ref_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    ref_g = 31'd1;
    cyc = 0;
  endtask

  // Advance n cycles, stepping the reference generator. tx_n: number of
  // leading cycles whose tx_bit is checked against the model; inj_at: cycle
  // whose bit gets inverted (its neighbours are checked too); timing: check
  // locked/done edges for a clean loopback run.
  task automatic run(input int n, input int inj_at, input int tx_n, input bit timing);
    for (int i = 0; i < n; i++) begin
      bif.inject_err = (cyc == inj_at);
      #1;
      if (cyc < tx_n) chk("tx_ref", 32'(bif.tx_bit), 32'(ref_g[30]));
      if (inj_at >= 0 && cyc >= inj_at - 1 && cyc <= inj_at + 1)
        chk("tx_inject", 32'(bif.tx_bit), 32'(ref_g[30] ^ (cyc == inj_at)));
      if (timing) begin
        if (cyc == 30)   chk("locked_pre", 32'(bif.locked), 32'd0);
        if (cyc == 31)   chk("locked_rise", 32'(bif.locked), 32'd1);
        if (cyc == 1054) chk("done_pre", 32'(bif.done), 32'd0);
        if (cyc == 1055) chk("done_rise", 32'(bif.done), 32'd1);
      end
      tick();
      ref_g = {ref_g[29:0], ref_g[30] ^ ref_g[27]};
      cyc++;
    end
    bif.inject_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bif.start      = 1'b0;
    bif.stop       = 1'b0;
    bif.inject_err = 1'b0;
    loop_en        = 1'b1;
    rx_force       = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(bif.state), 32'd0);
    chk("rst_tx", 32'(bif.tx_bit), 32'd0);
    chk("rst_err", 32'(bif.err_count), 32'd0);
    chk("rst_bits", 32'(bif.bit_count), 32'd0);
    chk("rst_lost", 32'(bif.lock_lost), 32'd0);
    chk("rst_locked", 32'(bif.locked), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean loopback run with reference sequence comparison.
    do_start();
    chk("seed_state", 32'(bif.state), 32'd1);
    #1;
    chk("tx_first", 32'(bif.tx_bit), 32'd0);
    run(30, -10, 62, 1'b1);
    chk("tx_bit31", 32'(bif.tx_bit), 32'd1);
    run(1030, -10, 62, 1'b1);
    chk("s1_state", 32'(bif.state), 32'd3);
    chk("s1_err", 32'(bif.err_count), 32'd0);
    chk("s1_bits", 32'(bif.bit_count), 32'd1024);
    chk("s1_lost", 32'(bif.lock_lost), 32'd0);

    // Single injected bit error from DONE: exactly three counted errors.
    do_start();
    run(1060, 99, 0, 1'b1);
    chk("s2_err", 32'(bif.err_count), 32'd3);
    chk("s2_bits", 32'(bif.bit_count), 32'd1024);
    chk("s2_lost", 32'(bif.lock_lost), 32'd0);

    // rx stuck at 1: eight errors per 39-cycle resync loop.
    loop_en  = 1'b0;
    rx_force = 1'b1;
    do_start();
    run(38, -10, 0, 1'b0);
    chk("s3_pre_state", 32'(bif.state), 32'd2);
    chk("s3_pre_err", 32'(bif.err_count), 32'd7);
    chk("s3_pre_lost", 32'(bif.lock_lost), 32'd0);
    run(1, -10, 0, 1'b0);
    chk("s3_rs1_state", 32'(bif.state), 32'd1);
    chk("s3_rs1_err", 32'(bif.err_count), 32'd8);
    chk("s3_rs1_bits", 32'(bif.bit_count), 32'd8);
    chk("s3_rs1_lost", 32'(bif.lock_lost), 32'd1);
    run(31, -10, 0, 1'b0);
    chk("s3_relock", 32'(bif.locked), 32'd1);
    run(8, -10, 0, 1'b0);
    chk("s3_rs2_state", 32'(bif.state), 32'd1);
    chk("s3_rs2_err", 32'(bif.err_count), 32'd16);
    bif.stop = 1'b1;
    tick();
    bif.stop = 1'b0;
    chk("s3_stop_state", 32'(bif.state), 32'd0);
    chk("s3_stop_err", 32'(bif.err_count), 32'd16);
    chk("s3_stop_lost", 32'(bif.lock_lost), 32'd1);

    // Stop mid-run at cycle 500, then start+stop together in IDLE.
    loop_en = 1'b1;
    do_start();
    run(499, -10, 0, 1'b0);
    bif.stop = 1'b1;
    tick();
    chk("s4_state", 32'(bif.state), 32'd0);
    chk("s4_bits", 32'(bif.bit_count), 32'd468);
    bif.inject_err = 1'b1;
    #1;
    chk("s4_tx_idle", 32'(bif.tx_bit), 32'd0);
    bif.inject_err = 1'b0;
    bif.start = 1'b1;
    tick();
    chk("s4_startstop", 32'(bif.state), 32'd0);
    chk("s4_bits_held", 32'(bif.bit_count), 32'd468);
    bif.start = 1'b0;
    bif.stop  = 1'b0;
    tick();

    // Reset during CHECK, then a full clean run reproduces the timing.
    do_start();
    run(200, -10, 0, 1'b0);
    chk("s5_in_check", 32'(bif.state), 32'd2);
    rst_n = 1'b0;
    bif.start = 1'b1;
    tick();
    rst_n = 1'b1;
    bif.start = 1'b0;
    chk("s5_state", 32'(bif.state), 32'd0);
    chk("s5_bits", 32'(bif.bit_count), 32'd0);
    chk("s5_err", 32'(bif.err_count), 32'd0);
    chk("s5_tx", 32'(bif.tx_bit), 32'd0);
    chk("s5_locked", 32'(bif.locked), 32'd0);
    do_start();
    run(1060, -10, 40, 1'b1);
    chk("s5_bits_end", 32'(bif.bit_count), 32'd1024);
    chk("s5_err_end", 32'(bif.err_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prbs31_bert_ctrl.md
Name: prbs31_bert_ctrl

Overview:
Bit-error-rate test controller for the PRBS31 link. It sequences the generator LFSR, synchronises the receive-side checker, and runs a measurement window of fixed length. It counts checked bits and bit errors, and forces a checker resync on loss of lock. It sits between the tile I/O (start/stop/inject from ui_in, tx/rx on uo_out/ui_in) and the status outputs.

Parameters:
WINDOW, 1024, number of checked bits per measurement (>= 1, < 2**CNT_W)
CNT_W, 16, width of bit and error counters
LOSS_THRESH, 8, consecutive checked-bit errors that declare loss of lock (>= 1)
SEED, 31'd1, generator seed loaded on start (must be nonzero)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
start  in  1  level; sampled in IDLE/DONE begins a run
stop  in  1  level; aborts run, returns to IDLE
inject_err  in  1  inverts tx_bit for every cycle it is high while generating
rx_bit  in  1  received serial bit, one per clk
tx_bit  out  1  generated PRBS31 bit
state  out  2  IDLE=0, SEED=1, CHECK=2, DONE=3
locked  out  1  high while state==CHECK
done  out  1  high while state==DONE
lock_lost  out  1  sticky: set on any resync, cleared by start
err_count  out  CNT_W  errors in current run, saturating at all-ones
bit_count  out  CNT_W  checked bits in current run

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; tx/checker LFSRs=0; load counter, consecutive-error counter, err_count, bit_count = 0; lock_lost=0; tx_bit=0.
- Generator: x^31+x^28+1. When state is SEED or CHECK: glfsr <= {glfsr[29:0], glfsr[30]^glfsr[27]}. tx_bit = glfsr[30] ^ inject_err. In IDLE/DONE glfsr holds and tx_bit=0 (inject ignored).
- Checker: in SEED/CHECK, clfsr <= {clfsr[29:0], rx_bit} every cycle. expected = clfsr[30]^clfsr[27] (pre-shift value). err = rx_bit ^ expected. err is evaluated only in CHECK.
- IDLE: if start && !stop, load glfsr=SEED, clear clfsr, counters, lock_lost, then -> SEED.
- SEED: load counter increments per cycle; after the 31st rx bit is shifted in (load counter==30) -> CHECK. Errors are not counted.
- CHECK: bit_count++ each cycle. If err, err_count++ (saturating) and consec++; else consec=0. When bit_count reaches WINDOW-1 in this cycle (its WINDOW-th check) -> DONE. When consec would reach LOSS_THRESH -> SEED (resync): load counter=0, consec=0, lock_lost=1. err_count and bit_count keep their values; glfsr keeps running.
- Simultaneous window-end and loss-of-lock: DONE wins, and lock_lost is still set.
- DONE: counters hold. start && !stop begins a new run exactly as from IDLE.
- stop in any state -> IDLE next cycle. Counters and lock_lost hold for readout. stop beats start when both are high.
- rst_n low mid-run overrides everything, including stop/start.
- Latency: start sampled at edge N. First generated bit at cycle N+1. In loopback (rx_bit=tx_bit), locked rises at N+32. done rises WINDOW cycles later.
- A single inverted bit yields exactly 3 counted errors: its own compare plus the compares where it sits at taps 27 and 30.
- Counter arithmetic: unsigned CNT_W. bit_count never exceeds WINDOW. err_count saturates and does not wrap.

Decomposition:
- Package prbs31_pkg: state enum (IDLE/SEED/CHECK/DONE), PRBS_LEN=31, TAP_A=30, TAP_B=27, default SEED.
- Sub-module prbs31_lfsr, instantiated twice:
  - Generator: enable, load, load_value; self-feedback.
  - Checker: enable, external shift-in bit, tap-XOR output.
- Controller FSM and counters stay in prbs31_bert_ctrl.

Test Plan:
- Loopback (rx_bit=tx_bit), WINDOW=1024, start pulse at cycle 0 -> locked at cycle 32, done at cycle 1056, err_count=0, bit_count=1024, lock_lost=0.
- Loopback, inject_err high for 1 cycle at cycle 100 -> err_count=3 at done, lock_lost=0, tx_bit inverted only at that cycle.
- rx_bit stuck 1, LOSS_THRESH=8 -> after 31 SEED cycles every check errors; returns to SEED after 8 CHECK cycles, lock_lost=1, err_count=8 after first resync and keeps growing by 8 per 39-cycle cycle.
- stop asserted at cycle 500 of a loopback run -> state=IDLE at 501, bit_count=468 held, tx_bit=0. start+stop together in IDLE -> stays IDLE.
- rst_n low for one edge during CHECK -> all outputs zero, state IDLE next cycle. start afterwards reproduces the scenario 1 timing.
- Compare tx_bit of the first 62 cycles after start against a reference x^31+x^28+1 model seeded with 1: first 30 bits 0, bit 31 = 1, exact match.
